// File: rtl/gwin_pkg.sv
// gwin_pkg: shared state type and sizing constants for the 5-row column window generator
package gwin_pkg;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  localparam int DEF_WIDTH = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int CNT_W = 12;
  localparam int COL_W = 40;
endpackage

// File: rtl/gwin_linebuf.sv
// gwin_linebuf: one WIDTH x 8 line buffer, synchronous read-before-write
module gwin_linebuf import gwin_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rd,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] mem [WIDTH];
  always_ff @(posedge i_clk) begin
    if (i_rd) o_rdata <= mem[i_addr];
    if (i_we) mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/gwin_ctrl.sv
// gwin_ctrl: raster to 5-row column window streamer (GWIN_FRAMECNT_EN adds o_frame_cnt)
module gwin_ctrl import gwin_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [7:0]       i_pixel,
  output logic [COL_W-1:0] o_col,
  output logic             o_valid,
  output logic             o_sol,
  output logic             o_eol,
  output logic             o_eof,
  output logic             o_err
`ifdef GWIN_FRAMECNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);
  localparam int AW = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] X_END = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] Y_END = CNT_W'(HEIGHT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] x, y, ex, ey, x_n, y_n;
  logic [1:0] wp, wp_n, sel;
  logic restart, acc, wrap, val_n, eof_n;
  logic [7:0] pix_q;
  logic [7:0] rd [4];
  always_comb begin
    restart = i_valid && i_sof && (state == IDLE || x != '0 || y != '0);
    acc = i_valid && (state != IDLE || i_sof);
    ex = restart ? '0 : x;
    ey = restart ? '0 : y;
    wrap = acc && ex == X_END;
    val_n = acc && ey >= CNT_W'(4);
    eof_n = val_n && ex == X_END && ey == Y_END;
    x_n = !acc ? x : wrap ? '0 : ex + 1'b1;
    y_n = !acc ? y : !wrap ? ey : ey == Y_END ? '0 : ey + 1'b1;
    wp_n = wp + 2'(wrap);
    state_n = !acc ? state :
              (wrap && ey == Y_END) ? IDLE :
              (wrap && ey == CNT_W'(3)) ? STREAM :
              restart ? FILL : state;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      x <= '0;
      y <= '0;
      wp <= '0;
      sel <= '0;
      pix_q <= '0;
      o_valid <= 1'b0;
      o_sol <= 1'b0;
      o_eol <= 1'b0;
      o_eof <= 1'b0;
      o_err <= 1'b0;
    end else begin
      x <= x_n;
      y <= y_n;
      wp <= wp_n;
      o_valid <= val_n;
      o_sol <= val_n && ex == '0;
      o_eol <= val_n && ex == X_END;
      o_eof <= eof_n;
      o_err <= o_err || (restart && state != IDLE);
      if (acc) begin
        sel <= wp;
        pix_q <= i_pixel;
      end
    end
  for (genvar i = 0; i < 4; i++) begin : g_buf
    gwin_linebuf #(.WIDTH(WIDTH)) u_buf (
      .i_clk(i_clk),
      .i_rd(acc),
      .i_we(acc && wp == 2'(i)),
      .i_addr(ex[AW-1:0]),
      .i_wdata(i_pixel),
      .o_rdata(rd[i])
    );
  end
  assign o_col = o_valid ? {rd[sel], rd[sel + 2'd1], rd[sel + 2'd2], rd[sel + 2'd3], pix_q} : '0;
`ifdef GWIN_FRAMECNT_EN
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_frame_cnt <= '0;
    else if (eof_n) o_frame_cnt <= o_frame_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_gwin_ctrl.sv
// tb_gwin_ctrl: randomized and directed checks of gwin_ctrl against a frame-image reference model
module tb_gwin_ctrl;
  localparam int W = 8;
  localparam int H = 6;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, sof = 1'b0;
  logic [7:0] pix = '0;
  logic [39:0] col;
  logic ov, sol, eol, eof, err;
`ifdef GWIN_FRAMECNT_EN
  logic [15:0] fcnt;
`endif
  gwin_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(valid),
    .i_sof(sof),
    .i_pixel(pix),
    .o_col(col),
    .o_valid(ov),
    .o_sol(sol),
    .o_eol(eol),
    .o_eof(eof),
    .o_err(err)
`ifdef GWIN_FRAMECNT_EN
    ,
    .o_frame_cnt(fcnt)
`endif
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0, nval = 0, neof = 0, m_eof = 0;
  logic [39:0] first_col, last_col;
  bit got_first;
  logic [7:0] img [H][W];
  bit active, merr;
  int mx, my;
  logic [39:0] e_col;
  logic e_v, e_sol, e_eol, e_eof;
  task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
    vecs++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask
  task automatic model(input logic v, input logic s, input logic [7:0] p);
    e_v = 0; e_col = '0; e_sol = 0; e_eol = 0; e_eof = 0;
    if (v && s && (!active || mx != 0 || my != 0)) begin
      if (active) merr = 1;
      active = 1; mx = 0; my = 0;
    end
    if (v && active) begin
      img[my][mx] = p;
      if (my >= 4) begin
        e_v = 1;
        e_col = {img[my-4][mx], img[my-3][mx], img[my-2][mx], img[my-1][mx], p};
        e_sol = (mx == 0);
        e_eol = (mx == W - 1);
        e_eof = e_eol && my == H - 1;
        if (e_eof) m_eof++;
      end
      mx++;
      if (mx == W) begin
        mx = 0; my++;
        if (my == H) begin my = 0; active = 0; end
      end
    end
  endtask
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    valid = v; sof = s; pix = p;
    model(v, s, p);
    @(posedge clk);
    #1;
    chk("valid", ov, e_v);
    chk("col", col, e_col);
    chk("sol", sol, e_sol);
    chk("eol", eol, e_eol);
    chk("eof", eof, e_eof);
    chk("err", err, merr);
    if (ov) begin
      nval++;
      if (!got_first) begin first_col = col; got_first = 1; end
      last_col = col;
    end
    if (eof) neof++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; valid = 0; sof = 0;
    #1;
    chk("rst_valid", ov, 0);
    chk("rst_col", col, 0);
    chk("rst_sol", sol, 0);
    chk("rst_eol", eol, 0);
    chk("rst_eof", eof, 0);
    chk("rst_err", err, 0);
    active = 0; merr = 0; mx = 0; my = 0; m_eof = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic frame(input bit rnd, input int gap, input int stop_y = H, input int stop_x = 0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (y == stop_y && x == stop_x) return;
        if (gap == 1 && !(y == 0 && x == 0)) step(0, 0, 8'h00);
        while (gap == 2 && $urandom_range(99) < 30) step(0, 1'($urandom_range(1)), 8'($urandom));
        step(1, y == 0 && x == 0, rnd ? 8'($urandom) : 8'(y * 16 + x));
      end
  endtask
  task automatic clr();
    nval = 0; neof = 0; got_first = 0;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 100; i++) step(1'($urandom_range(1)), 0, 8'($urandom));
    chk("pre_sof_err", err, 0);
    clr();
    frame(0, 0);
    chk("cont_count", nval, 16);
    chk("cont_first", first_col, 40'h0010203040);
    chk("cont_last", last_col, 40'h1727374757);
    chk("cont_eofs", neof, 1);
    clr();
    frame(0, 1);
    chk("tog_count", nval, 16);
    chk("tog_first", first_col, 40'h0010203040);
    chk("tog_last", last_col, 40'h1727374757);
    repeat (3) frame(1, 2);
    clr();
    frame(1, 0, 3, 2);
    frame(1, 0);
    chk("resync_err", err, 1);
    chk("resync_count", nval, 16);
    clr();
    frame(1, 2, 4, 3);
    frame(1, 2);
    chk("resync2_count", nval, 16 + 3);
    frame(1, 0, 5, 2);
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 8'($urandom));
    frame(1, 0);
    clr();
    frame(1, 0);
    frame(1, 0);
    chk("b2b_count", nval, 2 * W * (H - 4));
    chk("b2b_eofs", neof, 2);
`ifdef GWIN_FRAMECNT_EN
    chk("frame_cnt", fcnt, 40'(m_eof));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gwin_ctrl.md
GWIN_CTRL -- requirements
Module: gwin_ctrl

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line (2..4095).
REQ-002 Parameter HEIGHT, default 480, lines per frame (5..4095).
REQ-003 Port i_clk, input, 1, sole clock; all logic rising-edge.
REQ-004 Port i_rst, input, 1, reset: asynchronous, active-high.
REQ-005 Port i_valid, input, 1, raster pixel present on i_pixel.
REQ-006 Port i_sof, input, 1, qualifies i_valid pixel as frame pixel (0,0).
REQ-007 Port i_pixel, input, 8, luma sample, raster order.
REQ-008 Port o_col, output, 40, 5-row column, [39:32] oldest row (y-4) down to [7:0] current row (y).
REQ-009 Port o_valid, output, 1, o_col holds a full-height column.
REQ-010 Port o_sol, output, 1, first valid column of an output line (x=0).
REQ-011 Port o_eol, output, 1, last valid column of an output line (x=WIDTH-1).
REQ-012 Port o_eof, output, 1, last valid column of frame.
REQ-013 Port o_err, output, 1, sticky: frame resync occurred; cleared only by reset.

Function
REQ-014 FSM states IDLE, FILL, STREAM; reset state IDLE.
REQ-015 IDLE: ignore i_valid until i_valid&i_sof; that pixel is written at x=0,y=0, go FILL.
REQ-016 Counters x (0..WIDTH-1), y (0..HEIGHT-1) advance only on accepted pixel; x wraps to 0 and y increments at x=WIDTH-1.
REQ-017 Four line buffers, WIDTH x 8 each, in rotating ring; write pointer advances at each line wrap, modulo 4.
REQ-018 Each accepted pixel: read 4 stored rows at address x, write i_pixel to current-row buffer at address x, same cycle (read-before-write).
REQ-019 FILL: y<4, o_valid stays 0; on wrap into y=4 go STREAM.
REQ-020 STREAM: each accepted pixel yields o_valid=1 exactly one cycle later with o_col for that x; latency fixed at 1 cycle, no bubbles inserted.
REQ-021 o_sol/o_eol/o_eof asserted only together with o_valid; o_eof at x=WIDTH-1,y=HEIGHT-1.
REQ-022 After last frame pixel, return to IDLE; output count per frame = WIDTH*(HEIGHT-4).
REQ-023 i_sof with i_valid while not IDLE and not at (0,0) expected position: set o_err, restart at x=0,y=0 in FILL, pixel stored as row 0.
REQ-024 i_sof without i_valid ignored; gaps in i_valid hold all state.
REQ-025 o_col, o_valid, o_sol, o_eol, o_eof registered outputs; all 0 when not valid.

Reset
REQ-026 i_rst asserted: FSM IDLE, x=y=0, ring pointer 0, all outputs 0, o_err 0, within same cycle (async).
REQ-027 Reset mid-frame discards frame; line buffer contents need not be cleared.
REQ-028 Deassertion synchronised externally; first accepted pixel is the first i_sof after deassertion.

Configuration
REQ-029 Macro GWIN_FRAMECNT_EN defined: extra port o_frame_cnt, output, 16, count of o_eof pulses, wraps 0xFFFF->0, reset 0.
REQ-030 Macro undefined: port o_frame_cnt absent; no counter logic.

Structure
REQ-031 Package gwin_pkg holds FSM state enum, default WIDTH/HEIGHT constants, counter width constant (12), column width constant (40).
REQ-032 One sub-module gwin_linebuf: single line buffer, WIDTH x 8, sync read, one write port; instantiated four times.

Verification
REQ-033 WIDTH=8,HEIGHT=6, pixel=(y*16+x), continuous: 16 valid outputs; first o_col=0x0010203040 with o_sol; last o_col=0x1727374757 with o_eol and o_eof.
REQ-034 Same frame, i_valid toggling 1/0 each cycle: identical o_col sequence, each o_valid exactly 1 cycle after its input.
REQ-035 i_sof asserted at y=3,x=2 of frame: o_err=1, no o_valid until 4 further full lines received, then data from new frame only.
REQ-036 i_rst pulsed during STREAM (y=5): outputs 0 immediately, pixels without i_sof ignored afterward, next i_sof frame outputs correct.
REQ-037 Two back-to-back frames, WIDTH=640,HEIGHT=480: 2*640*476 valid outputs, 2 o_eof pulses, with GWIN_FRAMECNT_EN o_frame_cnt=2.
REQ-038 Pixels before first i_sof after reset (100 samples): no o_valid, no o_err.
